// File: rtl/stfq_rank_computer.sv
// Start-time fair queueing rank computer: stamps each packet with max(vtime, finish[flow])
// and hands it to the scheduler's two push lanes through a 2-slot output stage.
module stfq_rank_computer #(
    parameter int unsigned FLOWS = 10,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_1,
    input  logic [31:0]      in_value_1,
    input  logic [FLOWS-1:0] in_flow_1,
    input  logic [LEN_W-1:0] in_len_1,
    input  logic             in_valid_2,
    input  logic [31:0]      in_value_2,
    input  logic [FLOWS-1:0] in_flow_2,
    input  logic [LEN_W-1:0] in_len_2,
    output logic             in_ready_1,
    output logic             in_ready_2,
    output logic             push_1,
    output logic [31:0]      push_rank_1,
    output logic [31:0]      push_value_1,
    output logic [FLOWS-1:0] push_flow_1,
    output logic             push_2,
    output logic [31:0]      push_rank_2,
    output logic [31:0]      push_value_2,
    output logic [FLOWS-1:0] push_flow_2,
    input  logic             can_push_1,
    input  logic             can_push_2,
    input  logic             sched_pop,
    input  logic             deq_valid,
    input  logic [31:0]      deq_rank,
    output logic [31:0]      vtime,
    output logic             err_flow
);

    localparam int unsigned RANK_W = 32;
    localparam int unsigned SUM_W  = RANK_W + 1;

    typedef struct packed {
        logic              valid;
        logic [RANK_W-1:0] rank;
        logic [31:0]       value;
        logic [FLOWS-1:0]  flow;
    } slot_t;

    slot_t             slot_a_q, slot_a_d;
    slot_t             slot_b_q, slot_b_d;
    logic [RANK_W-1:0] vtime_q, vtime_d;
    logic              err_flow_q, err_flow_d;
    logic [RANK_W-1:0] finish_q [FLOWS];
    logic [RANK_W-1:0] finish_d [FLOWS];

    logic              acc_1, acc_2, wr_1, wr_2, ok_1, ok_2;
    logic [1:0]        occ, free;
    logic [RANK_W-1:0] fin_1, fin_2, start_1, start_2, end_1, end_2;
    slot_t             rem_a, rem_b, new_1, new_2;

    function automatic logic is_onehot(input logic [FLOWS-1:0] f);
        return (f != '0) && ((f & (f - FLOWS'(1))) == '0);
    endfunction

    function automatic logic [RANK_W-1:0] max_u(input logic [RANK_W-1:0] a,
                                                input logic [RANK_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Add a zero-extended length, clamping to all-ones on overflow.
    function automatic logic [RANK_W-1:0] sat_add(input logic [RANK_W-1:0] a,
                                                  input logic [LEN_W-1:0]  len);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(len);
        return sum[RANK_W] ? '1 : sum[RANK_W-1:0];
    endfunction

    assign push_rank_1  = slot_a_q.rank;
    assign push_value_1 = slot_a_q.value;
    assign push_flow_1  = slot_a_q.flow;
    assign push_rank_2  = slot_b_q.rank;
    assign push_value_2 = slot_b_q.value;
    assign push_flow_2  = slot_b_q.flow;
    assign vtime        = vtime_q;
    assign err_flow     = err_flow_q;

    always_comb begin
        push_1 = !rst && slot_a_q.valid && can_push_1 && !sched_pop;
        push_2 = push_1 && slot_b_q.valid && can_push_2;

        // Slots left occupied after this cycle's fire; B shifts into A when only A fires.
        if (push_2) begin
            rem_a = '0;
            rem_b = '0;
        end else if (push_1) begin
            rem_a = slot_b_q;
            rem_b = '0;
        end else begin
            rem_a = slot_a_q;
            rem_b = slot_b_q;
        end
        occ  = 2'(rem_a.valid) + 2'(rem_b.valid);
        free = 2'd2 - occ;

        in_ready_1 = !rst && (free != 2'd0);
        in_ready_2 = !rst && ((free == 2'd2) || ((free != 2'd0) && !in_valid_1));

        acc_1 = in_valid_1 && in_ready_1;
        acc_2 = in_valid_2 && in_ready_2;
        ok_1  = is_onehot(in_flow_1);
        ok_2  = is_onehot(in_flow_2);
        wr_1  = acc_1 && ok_1;
        wr_2  = acc_2 && ok_2;

        fin_1 = '0;
        fin_2 = '0;
        for (int i = 0; i < int'(FLOWS); i++) begin
            if (in_flow_1[i]) fin_1 = fin_1 | finish_q[i];
            if (in_flow_2[i]) fin_2 = fin_2 | finish_q[i];
        end

        start_1 = max_u(vtime_q, fin_1);
        end_1   = sat_add(start_1, in_len_1);
        start_2 = (wr_1 && (in_flow_1 == in_flow_2)) ? max_u(vtime_q, end_1)
                                                     : max_u(vtime_q, fin_2);
        end_2   = sat_add(start_2, in_len_2);

        new_1 = '{valid: 1'b1, rank: start_1, value: in_value_1, flow: in_flow_1};
        new_2 = '{valid: 1'b1, rank: start_2, value: in_value_2, flow: in_flow_2};

        // Lane 1 takes the lowest free slot first, then lane 2.
        slot_a_d = rem_a;
        slot_b_d = rem_b;
        if (wr_1) begin
            if (!slot_a_d.valid) slot_a_d = new_1;
            else                 slot_b_d = new_1;
        end
        if (wr_2) begin
            if (!slot_a_d.valid) slot_a_d = new_2;
            else                 slot_b_d = new_2;
        end

        // Lane 2 wins on a shared flow since its finish already chains off lane 1.
        for (int i = 0; i < int'(FLOWS); i++) begin
            finish_d[i] = finish_q[i];
            if (wr_2 && in_flow_2[i])      finish_d[i] = end_2;
            else if (wr_1 && in_flow_1[i]) finish_d[i] = end_1;
        end

        vtime_d    = (deq_valid && (deq_rank > vtime_q)) ? deq_rank : vtime_q;
        err_flow_d = (acc_1 && !ok_1) || (acc_2 && !ok_2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_a_q   <= '0;
            slot_b_q   <= '0;
            vtime_q    <= '0;
            err_flow_q <= 1'b0;
            for (int i = 0; i < int'(FLOWS); i++) finish_q[i] <= '0;
        end else begin
            slot_a_q   <= slot_a_d;
            slot_b_q   <= slot_b_d;
            vtime_q    <= vtime_d;
            err_flow_q <= err_flow_d;
            for (int i = 0; i < int'(FLOWS); i++) finish_q[i] <= finish_d[i];
        end
    end

endmodule

// File: tb/tb_stfq_rank_computer.sv
// Directed bench for stfq_rank_computer: rank arithmetic, output-stage flow control,
// virtual time, invalid flows, saturation and reset.
module tb_stfq_rank_computer;

    localparam int unsigned FLOWS = 10;
    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid_1, in_valid_2;
    logic [31:0]      in_value_1, in_value_2;
    logic [FLOWS-1:0] in_flow_1, in_flow_2;
    logic [LEN_W-1:0] in_len_1, in_len_2;
    logic             in_ready_1, in_ready_2;
    logic             push_1, push_2;
    logic [31:0]      push_rank_1, push_rank_2, push_value_1, push_value_2;
    logic [FLOWS-1:0] push_flow_1, push_flow_2;
    logic             can_push_1, can_push_2, sched_pop, deq_valid;
    logic [31:0]      deq_rank, vtime;
    logic             err_flow;

    int checks   = 0;
    int failures = 0;

    stfq_rank_computer #(.FLOWS(FLOWS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid_1(in_valid_1), .in_value_1(in_value_1), .in_flow_1(in_flow_1), .in_len_1(in_len_1),
        .in_valid_2(in_valid_2), .in_value_2(in_value_2), .in_flow_2(in_flow_2), .in_len_2(in_len_2),
        .in_ready_1(in_ready_1), .in_ready_2(in_ready_2),
        .push_1(push_1), .push_rank_1(push_rank_1), .push_value_1(push_value_1), .push_flow_1(push_flow_1),
        .push_2(push_2), .push_rank_2(push_rank_2), .push_value_2(push_value_2), .push_flow_2(push_flow_2),
        .can_push_1(can_push_1), .can_push_2(can_push_2), .sched_pop(sched_pop),
        .deq_valid(deq_valid), .deq_rank(deq_rank), .vtime(vtime), .err_flow(err_flow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid_1 = 1'b0; in_value_1 = '0; in_flow_1 = '0; in_len_1 = '0;
        in_valid_2 = 1'b0; in_value_2 = '0; in_flow_2 = '0; in_len_2 = '0;
        sched_pop  = 1'b0; deq_valid = 1'b0; deq_rank = '0;
    endtask

    task automatic lane1(input logic [FLOWS-1:0] f, input logic [LEN_W-1:0] l, input logic [31:0] v);
        in_valid_1 = 1'b1; in_flow_1 = f; in_len_1 = l; in_value_1 = v;
    endtask

    task automatic lane2(input logic [FLOWS-1:0] f, input logic [LEN_W-1:0] l, input logic [31:0] v);
        in_valid_2 = 1'b1; in_flow_2 = f; in_len_2 = l; in_value_2 = v;
    endtask

    initial begin
        idle();
        rst = 1'b1; can_push_1 = 1'b1; can_push_2 = 1'b1;
        lane1(10'h001, 16'd1, 32'h0);
        cyc(); #1;
        chk("rst_push_1", push_1, 1'b0);
        chk("rst_ready_1", in_ready_1, 1'b0);
        chk("rst_ready_2", in_ready_2, 1'b0);
        cyc();
        rst = 1'b0; idle(); #1;
        chk("rst_vtime", vtime, 32'd0);
        chk("rst_err", err_flow, 1'b0);
        chk("rst_empty", push_1, 1'b0);

        // Single-lane packets on flow 0x1
        lane1(10'h001, 16'd100, 32'hA1); #1;
        chk("t1_ready_1", in_ready_1, 1'b1);
        cyc(); idle(); lane1(10'h001, 16'd50, 32'hB2); #1;
        chk("t1_push_1", push_1, 1'b1);
        chk("t1_rank_a", push_rank_1, 32'd0);
        chk("t1_value_a", push_value_1, 32'hA1);
        chk("t1_flow_a", push_flow_1, 32'h001);
        chk("t1_push_2", push_2, 1'b0);
        cyc(); idle(); #1;
        chk("t1_push_b", push_1, 1'b1);
        chk("t1_rank_b", push_rank_1, 32'd100);
        cyc(); #1;
        chk("t1_drained", push_1, 1'b0);

        // Same flow on both lanes in one cycle
        lane1(10'h004, 16'd10, 32'hC0); lane2(10'h004, 16'd20, 32'hC1); #1;
        chk("t2_ready_2", in_ready_2, 1'b1);
        cyc(); idle(); lane1(10'h004, 16'd1, 32'hC2); #1;
        chk("t2_push_1", push_1, 1'b1);
        chk("t2_push_2", push_2, 1'b1);
        chk("t2_rank_1", push_rank_1, 32'd0);
        chk("t2_rank_2", push_rank_2, 32'd10);
        cyc(); idle(); #1;
        chk("t2_finish_chain", push_rank_1, 32'd30);
        cyc();

        // Virtual time
        deq_valid = 1'b1; deq_rank = 32'd500;
        cyc(); idle(); lane1(10'h002, 16'd5, 32'hD0); #1;
        chk("t3_vtime_500", vtime, 32'd500);
        cyc(); idle(); deq_valid = 1'b1; deq_rank = 32'd300; #1;
        chk("t3_rank_vtime", push_rank_1, 32'd500);
        cyc(); idle(); #1;
        chk("t3_vtime_mono", vtime, 32'd500);
        deq_valid = 1'b1; deq_rank = 32'd800; lane1(10'h008, 16'd1, 32'hD1);
        cyc(); idle(); #1;
        chk("t3_old_vtime", push_rank_1, 32'd500);
        chk("t3_vtime_800", vtime, 32'd800);
        cyc();

        // Back-pressure and B-to-A shift
        can_push_1 = 1'b0;
        lane1(10'h010, 16'd7, 32'hE0); lane2(10'h020, 16'd9, 32'hE1);
        cyc(); idle(); #1;
        chk("t4_blocked_1", push_1, 1'b0);
        chk("t4_blocked_2", push_2, 1'b0);
        chk("t4_full_ready_1", in_ready_1, 1'b0);
        chk("t4_full_ready_2", in_ready_2, 1'b0);
        cyc(); #1;
        chk("t4_hold_rank_a", push_rank_1, 32'd800);
        chk("t4_hold_flow_a", push_flow_1, 32'h010);
        chk("t4_hold_flow_b", push_flow_2, 32'h020);
        can_push_1 = 1'b1; can_push_2 = 1'b0; lane1(10'h040, 16'd3, 32'hE2); #1;
        chk("t4_a_only_1", push_1, 1'b1);
        chk("t4_a_only_2", push_2, 1'b0);
        chk("t4_one_free_r1", in_ready_1, 1'b1);
        chk("t4_one_free_r2", in_ready_2, 1'b0);
        cyc(); idle(); can_push_2 = 1'b1; #1;
        chk("t4_shift_flow_a", push_flow_1, 32'h020);
        chk("t4_new_flow_b", push_flow_2, 32'h040);
        chk("t4_both_push", push_2, 1'b1);
        chk("t4_rank_b", push_rank_2, 32'd800);
        cyc(); #1;
        chk("t4_drained", push_1, 1'b0);

        // sched_pop suppresses pushes
        lane1(10'h080, 16'd1, 32'hF0);
        cyc(); idle(); sched_pop = 1'b1; #1;
        chk("t5_pop_block", push_1, 1'b0);
        cyc(); sched_pop = 1'b0; #1;
        chk("t5_release", push_1, 1'b1);
        chk("t5_flow", push_flow_1, 32'h080);
        cyc(); idle();

        // Invalid flows
        lane1(10'h003, 16'd5, 32'h11); #1;
        chk("t6_bad_ready", in_ready_1, 1'b1);
        cyc(); idle(); #1;
        chk("t6_no_push", push_1, 1'b0);
        chk("t6_err_pulse", err_flow, 1'b1);
        cyc(); #1;
        chk("t6_err_clear", err_flow, 1'b0);
        lane1(10'h000, 16'd5, 32'h12); lane2(10'h300, 16'd5, 32'h13);
        cyc(); idle(); #1;
        chk("t6_both_err", err_flow, 1'b1);
        chk("t6_both_no_push", push_1, 1'b0);
        cyc(); #1;
        chk("t6_single_pulse", err_flow, 1'b0);

        // Saturation of finish time
        deq_valid = 1'b1; deq_rank = 32'hFFFF_FFF0;
        cyc(); idle(); lane1(10'h001, 16'h0020, 32'h21); #1;
        chk("t7_vtime_hi", vtime, 32'hFFFF_FFF0);
        cyc(); idle(); lane1(10'h001, 16'd1, 32'h22); #1;
        chk("t7_rank_hi", push_rank_1, 32'hFFFF_FFF0);
        cyc(); idle(); #1;
        chk("t7_sat", push_rank_1, 32'hFFFF_FFFF);
        cyc();

        // Reset with both slots full
        can_push_1 = 1'b0;
        lane1(10'h001, 16'd1, 32'h31); lane2(10'h002, 16'd1, 32'h32);
        cyc(); idle(); can_push_1 = 1'b1; rst = 1'b1; #1;
        chk("t8_rst_push_1", push_1, 1'b0);
        chk("t8_rst_push_2", push_2, 1'b0);
        cyc(); rst = 1'b0; #1;
        chk("t8_discarded", push_1, 1'b0);
        chk("t8_vtime", vtime, 32'd0);
        lane1(10'h001, 16'd7, 32'h33);
        cyc(); idle(); #1;
        chk("t8_finish_cleared", push_rank_1, 32'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
